// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keypad receiver: frame FSM state type,
// the scancodes the keypad path cares about, the key codes handed to the
// CPU, and the scancode-to-key-code mapping function.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Make codes for digits 0-9
  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  // Make codes for letters A-F
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  localparam logic [4:0] KEY_ENTER = 5'd16;
  localparam logic [4:0] KEY_BKSP  = 5'd17;

  // Returns {hit, key_code}; hit=0 means the byte is not a keypad key.
  function automatic logic [5:0] map_scancode(input logic [7:0] sc);
    logic [5:0] res;
    res = 6'd0;
    case (sc)
      SC_0:     res = {1'b1, 5'd0};
      SC_1:     res = {1'b1, 5'd1};
      SC_2:     res = {1'b1, 5'd2};
      SC_3:     res = {1'b1, 5'd3};
      SC_4:     res = {1'b1, 5'd4};
      SC_5:     res = {1'b1, 5'd5};
      SC_6:     res = {1'b1, 5'd6};
      SC_7:     res = {1'b1, 5'd7};
      SC_8:     res = {1'b1, 5'd8};
      SC_9:     res = {1'b1, 5'd9};
      SC_A:     res = {1'b1, 5'd10};
      SC_B:     res = {1'b1, 5'd11};
      SC_C:     res = {1'b1, 5'd12};
      SC_D:     res = {1'b1, 5'd13};
      SC_E:     res = {1'b1, 5'd14};
      SC_F:     res = {1'b1, 5'd15};
      SC_ENTER: res = {1'b1, KEY_ENTER};
      SC_BKSP:  res = {1'b1, KEY_BKSP};
      default:  res = 6'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_keypad_rx_filter.sv
// ps2_line_filter
// Conditions one raw PS/2 pin: a 2-FF synchronizer followed by a glitch
// filter whose output only changes after FILTER_LEN consecutive
// synchronized samples disagree with it.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset (output forced to 1)
//   line_in  - raw asynchronous pin
//   line_out - filtered, synchronous line level
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_out
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] run_cnt;

  // Synchronize the pin, then count how long the synchronized level has
  // disagreed with the filtered level; any agreeing sample restarts the run.
  // Everything idles high so a frame in flight at reset is ignored until
  // the line genuinely changes again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1   <= 1'b1;
      sync_2   <= 1'b1;
      run_cnt  <= '0;
      line_out <= 1'b1;
    end else begin
      sync_1 <= line_in;
      sync_2 <= sync_1;
      if (sync_2 == line_out) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        line_out <= sync_2;
        run_cnt  <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keypad_rx.sv
// ps2_keypad_rx
// PS/2 keyboard receiver for the CPU keyboard IO path. Filters the PS/2
// lines, deframes 11-bit frames with odd parity, drops break/extended
// prefixes and release codes, maps keypad make codes to 5-bit key codes
// and buffers them in a small FIFO drained by a one-cycle pop strobe.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   ps2_clk, ps2_data   - raw asynchronous PS/2 pins
//   pop                 - consume head entry (ignored when empty)
//   key_valid           - FIFO not empty
//   key_code            - head entry (0 when empty)
//   key_count           - FIFO occupancy
//   overflow            - sticky, a code was dropped on full
//   err_count           - saturating parity/stop/timeout error count
module ps2_keypad_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          pop,
  output logic                          key_valid,
  output logic [4:0]                    key_code,
  output logic [$clog2(FIFO_DEPTH):0]   key_count,
  output logic                          overflow,
  output logic [7:0]                    err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  logic clk_filt, data_filt, clk_prev, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst(rst), .line_in(ps2_clk), .line_out(clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst(rst), .line_in(ps2_data), .line_out(data_filt)
  );

  assign fall = clk_prev & ~clk_filt;

  ps2_state_t      state, state_next;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            parity_bit;
  logic [TW-1:0]   to_cnt;
  logic            frame_ok, frame_err, timeout;
  logic [7:0]      rx_byte;
  logic            rx_strobe;
  logic            brk, ext;
  logic [5:0]      map_res;
  logic            push, do_pop, full, wr_en;
  logic [4:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Frame sequencing: every step is taken on a filtered clock fall, except
  // the timeout which abandons a stalled frame. Parity is odd over the
  // eight data bits plus the parity bit.
  always_comb begin
    state_next = state;
    frame_ok   = 1'b0;
    frame_err  = 1'b0;
    timeout    = 1'b0;
    if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
      timeout    = 1'b1;
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_filt) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          if (data_filt && (^{shift_reg, parity_bit})) frame_ok = 1'b1;
          else                                         frame_err = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame datapath: edge detect, bit shifting (LSB first), stall counter
  // and the one-cycle strobe that hands a good byte to the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev   <= 1'b1;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      rx_strobe  <= 1'b0;
    end else begin
      clk_prev  <= clk_filt;
      rx_strobe <= frame_ok;
      if (frame_ok) rx_byte <= shift_reg;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift_reg <= {data_filt, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
          PARITY:  parity_bit <= data_filt;
          default: ;
        endcase
      end
    end
  end

  // Decoder: prefixes only set flags; a byte following F0 is a release.
  // E0 5A lands on the same Enter code as the main Enter key, so ext only
  // needs tracking and clearing.
  assign map_res = map_scancode(rx_byte);
  assign push    = rx_strobe && rx_byte != SC_BREAK && rx_byte != SC_EXT &&
                   !brk && map_res[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (rx_strobe) begin
      if (rx_byte == SC_BREAK) begin
        brk <= 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext <= 1'b1;
      end else if (brk) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (ext) begin
        ext <= 1'b0;
      end
    end
  end

  // Error counter saturates so software can tell "many" from wraparound.
  always_ff @(posedge clk) begin
    if (rst)                                             err_count <= '0;
    else if ((frame_err || timeout) && err_count != 8'hFF) err_count <= err_count + 1'b1;
  end

  // FIFO: a simultaneous pop frees the slot, so a push into a full FIFO
  // still lands when the CPU pops in the same cycle.
  assign do_pop = pop && key_valid;
  assign full   = (fifo_cnt == DEPTH_L);
  assign wr_en  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= map_res[4:0];
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

  assign key_valid = (fifo_cnt != '0);
  assign key_code  = key_valid ? mem[rd_ptr] : 5'd0;
  assign key_count = fifo_cnt;

endmodule

// File: tb/tb_ps2_keypad_rx.sv
// tb_ps2_keypad_rx
// Self-checking bench for ps2_keypad_rx: a table of single make codes
// followed by hand-written sequences for prefixes, parity errors,
// timeouts, overflow with a same-cycle pop, and mid-frame reset.
module tb_ps2_keypad_rx;

  localparam int FILTER_LEN  = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       pop;
  logic       key_valid;
  logic [4:0] key_code;
  logic [2:0] key_count;
  logic       overflow;
  logic [7:0] err_count;

  int checks  = 0;
  int errors  = 0;
  int exp_err = 0;
  int exp_q[$];

  typedef struct {
    logic [7:0] sc;
    int         code;
  } vec_t;

  vec_t vecs[18];

  ps2_keypad_rx #(
    .FILTER_LEN(FILTER_LEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .pop(pop),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_count(key_count),
    .overflow(overflow),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Start bit, 8 data bits LSB first, odd parity (optionally corrupted), stop.
  function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit flip_par);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (~^b) ^ flip_par;
    f[10]  = 1'b1;
    return f;
  endfunction

  // Drive frame bits first..last. With pop_at_push the pop strobe is
  // placed in the cycle the stop-bit code is pushed: 2 sync + FILTER_LEN
  // cycles to the fall, one to sample it, then the push cycle.
  task automatic driveBits(input logic [10:0] f, input int first, input int last,
                           input bit pop_at_push);
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_push && i == 10) begin
        repeat (FILTER_LEN + 3) @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        repeat (HALF - FILTER_LEN - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit flip_par);
    driveBits(makeFrame(b, flip_par), 0, 10, 1'b0);
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Pop everything the scoreboard expects, comparing each head entry.
  task automatic drainAndCheck(input string name);
    int e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({name, " valid"}, int'(key_valid), 1);
      checkOutput({name, " code"}, int'(key_code), e);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
    end
    checkOutput({name, " empty"}, int'(key_valid), 0);
  endtask

  initial begin
    logic [10:0] f;

    vecs = '{
      '{8'h45, 0},  '{8'h16, 1},  '{8'h1E, 2},  '{8'h26, 3},
      '{8'h25, 4},  '{8'h2E, 5},  '{8'h36, 6},  '{8'h3D, 7},
      '{8'h3E, 8},  '{8'h46, 9},  '{8'h1C, 10}, '{8'h32, 11},
      '{8'h21, 12}, '{8'h23, 13}, '{8'h24, 14}, '{8'h2B, 15},
      '{8'h5A, 16}, '{8'h66, 17}
    };

    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    pop      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst key_valid", int'(key_valid), 0);
    checkOutput("rst key_code", int'(key_code), 0);
    checkOutput("rst key_count", int'(key_count), 0);
    checkOutput("rst overflow", int'(overflow), 0);
    checkOutput("rst err_count", int'(err_count), 0);

    $display("[TB] make code table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].sc, 1'b0);
      exp_q.push_back(vecs[i].code);
      checkOutput($sformatf("table %0d count", i), int'(key_count), 1);
      drainAndCheck($sformatf("table %0d", i));
    end

    $display("[TB] release sequence");
    applyStimulus(8'h16, 1'b0); exp_q.push_back(1);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h16, 1'b0);
    checkOutput("release count", int'(key_count), 1);
    drainAndCheck("release");

    $display("[TB] extended enter, backspace, A");
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h5A, 1'b0); exp_q.push_back(16);
    applyStimulus(8'h66, 1'b0); exp_q.push_back(17);
    applyStimulus(8'h1C, 1'b0); exp_q.push_back(10);
    checkOutput("ext count", int'(key_count), 3);
    drainAndCheck("ext");

    $display("[TB] unmapped byte");
    applyStimulus(8'h1D, 1'b0);
    checkOutput("unmapped count", int'(key_count), 0);
    checkOutput("unmapped err", int'(err_count), exp_err);

    $display("[TB] parity error");
    applyStimulus(8'h16, 1'b1);
    exp_err++;
    checkOutput("parity count", int'(key_count), 0);
    applyStimulus(8'h1E, 1'b0); exp_q.push_back(2);
    checkOutput("parity err", int'(err_count), exp_err);
    drainAndCheck("parity");

    $display("[TB] timeout");
    f = makeFrame(8'h26, 1'b0);
    driveBits(f, 0, 4, 1'b0);
    ps2_data = 1'b1;
    repeat (TIMEOUT_CYC + 200) @(negedge clk);
    exp_err++;
    checkOutput("timeout err", int'(err_count), exp_err);
    applyStimulus(8'h45, 1'b0); exp_q.push_back(0);
    checkOutput("timeout count", int'(key_count), 1);
    drainAndCheck("timeout");

    $display("[TB] overflow");
    applyStimulus(8'h45, 1'b0);
    applyStimulus(8'h16, 1'b0);
    applyStimulus(8'h1E, 1'b0);
    applyStimulus(8'h26, 1'b0);
    applyStimulus(8'h25, 1'b0);
    checkOutput("ovf count", int'(key_count), 4);
    checkOutput("ovf flag", int'(overflow), 1);
    checkOutput("ovf head", int'(key_code), 0);
    driveBits(makeFrame(8'h2E, 1'b0), 0, 10, 1'b1);
    repeat (2 * HALF) @(negedge clk);
    checkOutput("ovf push+pop count", int'(key_count), 4);
    checkOutput("ovf flag sticky", int'(overflow), 1);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(5);
    drainAndCheck("ovf");

    $display("[TB] reset mid-frame");
    applyStimulus(8'h1E, 1'b0);
    applyStimulus(8'h26, 1'b0);
    checkOutput("mrst pre count", int'(key_count), 2);
    f = makeFrame(8'h16, 1'b0);
    driveBits(f, 0, 3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mrst key_valid", int'(key_valid), 0);
    checkOutput("mrst key_code", int'(key_code), 0);
    checkOutput("mrst key_count", int'(key_count), 0);
    checkOutput("mrst overflow", int'(overflow), 0);
    checkOutput("mrst err_count", int'(err_count), 0);
    driveBits(f, 4, 10, 1'b0);
    ps2_data = 1'b1;
    repeat (TIMEOUT_CYC + 200) @(negedge clk);
    checkOutput("mrst orphan count", int'(key_count), 0);
    // Remaining bits of 0x16 start a bogus frame that stalls in DATA.
    exp_err = 1;
    checkOutput("mrst orphan err", int'(err_count), exp_err);
    applyStimulus(8'h1E, 1'b0); exp_q.push_back(2);
    drainAndCheck("mrst after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
